zbin_pt_accumulator: RTL

Accumulates track pT into a z-bin × eta-bin grid, one event at a time, then streams the grid cell by cell to the jet-clustering stage. It sits directly downstream of the z-to-z-bin converter. Each track carries one even z-bin (`zbin1`) and optionally one odd overlap z-bin (`zbin2`). Both are accumulated in the same cycle, and each cell is cleared as it is read out.

---
 rtl/jet_pkg.sv | 27 ++
 rtl/zbin_pt_accumulator_if.sv | 45 ++++
 rtl/pt_sat_add.sv | 26 ++
 rtl/zbin_pt_accumulator.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/jet_pkg.sv
// ============================================================================
// Module      : jet_pkg
// Description : Shared constants and state encoding for the jet-finder z-bin
//               pT accumulation path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jet_pkg;

  localparam int NZBIN_DEF   = 6;
  localparam int NETA_DEF    = 16;
  localparam int ETA_W_DEF   = 4;
  localparam int PT_IN_W_DEF = 14;
  localparam int PT_W_DEF    = 16;

  localparam logic [3:0] ZBIN_NONE = 4'hF;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    DRAIN   = 2'd1,
    READOUT = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/zbin_pt_accumulator_if.sv
// ============================================================================
// Module      : zbin_pt_accumulator_if
// Description : Track input stream and grid-cell output stream of the
//               z-bin pT accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface zbin_pt_accumulator_if
  import jet_pkg::*;
#(
  parameter int ETA_W   = ETA_W_DEF,
  parameter int PT_IN_W = PT_IN_W_DEF,
  parameter int PT_W    = PT_W_DEF
) ();

  logic               in_valid;
  logic               in_ready;
  logic [PT_IN_W-1:0] in_pt;
  logic [ETA_W-1:0]   in_eta;
  logic [3:0]         in_zbin1;
  logic [3:0]         in_zbin2;
  logic               in_last;

  logic               out_valid;
  logic               out_ready;
  logic [3:0]         out_zbin;
  logic [ETA_W-1:0]   out_eta;
  logic [PT_W-1:0]    out_pt;
  logic               out_last;

  // master: track source and grid consumer; slave: the accumulator
  modport master (
    output in_valid, in_pt, in_eta, in_zbin1, in_zbin2, in_last, out_ready,
    input  in_ready, out_valid, out_zbin, out_eta, out_pt, out_last
  );

  modport slave (
    input  in_valid, in_pt, in_eta, in_zbin1, in_zbin2, in_last, out_ready,
    output in_ready, out_valid, out_zbin, out_eta, out_pt, out_last
  );

endinterface

`default_nettype wire

// File: rtl/pt_sat_add.sv
// ============================================================================
// Module      : pt_sat_add
// Description : Unsigned accumulator + track pT adder, clamps at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pt_sat_add
  import jet_pkg::*;
#(
  parameter int PT_W    = PT_W_DEF,
  parameter int PT_IN_W = PT_IN_W_DEF
) (
  input  wire logic [PT_W-1:0]    i_acc,
  input  wire logic [PT_IN_W-1:0] i_pt,
  output logic      [PT_W-1:0]    o_sum
);

  logic [PT_W:0] w_full;

  assign w_full = {1'b0, i_acc} + {{(PT_W + 1 - PT_IN_W){1'b0}}, i_pt};
  assign o_sum  = w_full[PT_W] ? {PT_W{1'b1}} : w_full[PT_W-1:0];

endmodule

`default_nettype wire

// File: rtl/zbin_pt_accumulator.sv
// ============================================================================
// Module      : zbin_pt_accumulator
// Description : Accumulates track pT into a z-bin x eta-bin grid per event,
//               then streams and clears the grid cell by cell.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module zbin_pt_accumulator
  import jet_pkg::*;
#(
  parameter int NZBIN   = NZBIN_DEF,
  parameter int NETA    = NETA_DEF,
  parameter int ETA_W   = ETA_W_DEF,
  parameter int PT_IN_W = PT_IN_W_DEF,
  parameter int PT_W    = PT_W_DEF
) (
  input wire logic             clk,
  input wire logic             reset,
  zbin_pt_accumulator_if.slave bus
);

  state_t r_state, w_state_nxt;
  logic   w_in_ready, w_in_fire, w_out_fire;

  logic               r_s1_valid;
  logic [PT_IN_W-1:0] r_s1_pt;
  logic [ETA_W-1:0]   r_s1_eta;
  logic [3:0]         r_s1_z1, r_s1_z2;
  logic               w_z2_en;

  logic [PT_W-1:0] r_acc [NZBIN][NETA];
  logic [PT_W-1:0] w_cur1, w_cur2, w_sum1, w_sum2, w_ld_pt;

  logic [3:0]       r_rd_z, w_nxt_z, w_ld_z;
  logic [ETA_W-1:0] r_rd_eta, w_nxt_eta, w_ld_eta;
  logic             w_is_last_cell, w_load;

  logic             r_out_valid, r_out_last;
  logic [PT_W-1:0]  r_out_pt;
  logic [3:0]       r_out_zbin;
  logic [ETA_W-1:0] r_out_eta;

  assign w_in_fire  = bus.in_valid & w_in_ready;
  assign w_out_fire = r_out_valid & bus.out_ready;
  // duplicate or absent overlap bin must not add a second time
  assign w_z2_en    = (r_s1_z2 != ZBIN_NONE) && (r_s1_z2 != r_s1_z1);

  assign w_is_last_cell = (r_rd_z == 4'(NZBIN - 1)) && (r_rd_eta == ETA_W'(NETA - 1));
  assign w_nxt_z   = (r_rd_eta == ETA_W'(NETA - 1)) ? r_rd_z + 4'd1 : r_rd_z;
  assign w_nxt_eta = (r_rd_eta == ETA_W'(NETA - 1)) ? '0 : r_rd_eta + 1'b1;
  // first READOUT cycle loads the pointer cell; each later load is one ahead
  assign w_ld_z    = r_out_valid ? w_nxt_z   : r_rd_z;
  assign w_ld_eta  = r_out_valid ? w_nxt_eta : r_rd_eta;
  assign w_load    = (r_state == READOUT) &&
                     (!r_out_valid || (w_out_fire && !w_is_last_cell));

  always_ff @(posedge clk) begin
    if (reset) r_state <= ACCUM;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      ACCUM: begin
        w_in_ready = 1'b1;
        if (bus.in_valid && bus.in_last) w_state_nxt = DRAIN;
      end
      DRAIN:   w_state_nxt = READOUT;
      READOUT: if (w_out_fire && w_is_last_cell) w_state_nxt = ACCUM;
      default: w_state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_pt    <= '0;
      r_s1_eta   <= '0;
      r_s1_z1    <= '0;
      r_s1_z2    <= '0;
    end else begin
      r_s1_valid <= w_in_fire;
      if (w_in_fire) begin
        r_s1_pt  <= bus.in_pt;
        r_s1_eta <= bus.in_eta;
        r_s1_z1  <= bus.in_zbin1;
        r_s1_z2  <= bus.in_zbin2;
      end
    end
  end

  // out-of-range z or eta indices match no cell, so those adds vanish
  always_comb begin
    w_cur1  = '0;
    w_cur2  = '0;
    w_ld_pt = '0;
    for (int z = 0; z < NZBIN; z++) begin
      for (int e = 0; e < NETA; e++) begin
        if (r_s1_z1 == 4'(z) && r_s1_eta == ETA_W'(e)) w_cur1  = r_acc[z][e];
        if (r_s1_z2 == 4'(z) && r_s1_eta == ETA_W'(e)) w_cur2  = r_acc[z][e];
        if (w_ld_z  == 4'(z) && w_ld_eta == ETA_W'(e)) w_ld_pt = r_acc[z][e];
      end
    end
  end

  pt_sat_add #(.PT_W(PT_W), .PT_IN_W(PT_IN_W)) u_add1 (
    .i_acc (w_cur1),
    .i_pt  (r_s1_pt),
    .o_sum (w_sum1)
  );

  pt_sat_add #(.PT_W(PT_W), .PT_IN_W(PT_IN_W)) u_add2 (
    .i_acc (w_cur2),
    .i_pt  (r_s1_pt),
    .o_sum (w_sum2)
  );

  // S1 commits only in ACCUM/DRAIN, clears only in READOUT: never both
  always_ff @(posedge clk) begin
    for (int z = 0; z < NZBIN; z++) begin
      for (int e = 0; e < NETA; e++) begin
        if (reset)
          r_acc[z][e] <= '0;
        else if (w_out_fire && r_rd_z == 4'(z) && r_rd_eta == ETA_W'(e))
          r_acc[z][e] <= '0;
        else if (r_s1_valid && r_s1_z1 == 4'(z) && r_s1_eta == ETA_W'(e))
          r_acc[z][e] <= w_sum1;
        else if (r_s1_valid && w_z2_en && r_s1_z2 == 4'(z) && r_s1_eta == ETA_W'(e))
          r_acc[z][e] <= w_sum2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_z      <= '0;
      r_rd_eta    <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_pt    <= '0;
      r_out_zbin  <= '0;
      r_out_eta   <= '0;
    end else begin
      if (r_state == DRAIN) begin
        r_rd_z   <= '0;
        r_rd_eta <= '0;
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_pt    <= w_ld_pt;
        r_out_zbin  <= w_ld_z;
        r_out_eta   <= w_ld_eta;
        r_out_last  <= (w_ld_z == 4'(NZBIN - 1)) && (w_ld_eta == ETA_W'(NETA - 1));
        r_rd_z      <= w_ld_z;
        r_rd_eta    <= w_ld_eta;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.out_pt    = r_out_pt;
  assign bus.out_zbin  = r_out_zbin;
  assign bus.out_eta   = r_out_eta;

endmodule

`default_nettype wire
